// File: rtl/core_prefetch_pkg.sv
// core_prefetch_pkg: shared constants and types for the instruction prefetch buffer.
package core_prefetch_pkg;
    localparam int PREFETCH_DEPTH_DEFAULT = 4;
    typedef logic [29:0] word_addr_t;
    typedef logic [31:0] instr_word_t;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;
endpackage

// File: rtl/core_instr_prefetch_ring.sv
// prefetch_ring: DEPTH-entry circular word buffer with push, pop, flush, occupancy and head word.
module prefetch_ring
    import core_prefetch_pkg::*;
#(
    parameter int DEPTH = PREFETCH_DEPTH_DEFAULT,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  instr_word_t   push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output instr_word_t   head_o
);
    instr_word_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Push and pop in one cycle move both pointers and leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_i);
        rd_ptr_d = flush_i ? wr_ptr_d : rd_ptr_q + PW'(pop_i);
        count_d  = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/core_instr_prefetch.sv
// core_instr_prefetch: sequential instruction prefetch buffer between fetch (naive_bus slave) and RAM (naive_bus master).
// INSTR_PREFETCH_EN enables buffering; without it the block is a stateless pass-through.
module core_instr_prefetch
    import core_prefetch_pkg::*;
#(
    parameter int DEPTH = PREFETCH_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_rd_req_i,
    input  logic [3:0]  instr_rd_be_i,
    input  logic [31:0] instr_rd_addr_i,
    output logic        instr_rd_gnt_o,
    output logic [31:0] instr_rd_data_o,
    output logic        instr_wr_gnt_o,
    output logic        ram_rd_req_o,
    output logic [3:0]  ram_rd_be_o,
    output logic [31:0] ram_rd_addr_o,
    input  logic        ram_rd_gnt_i,
    input  logic [31:0] ram_rd_data_i,
    output logic        ram_wr_req_o,
    output logic [3:0]  ram_wr_be_o,
    output logic [31:0] ram_wr_addr_o,
    output logic [31:0] ram_wr_data_o
);
    assign instr_wr_gnt_o = 1'b0;
    assign ram_wr_req_o   = 1'b0;
    assign ram_wr_be_o    = 4'h0;
    assign ram_wr_addr_o  = '0;
    assign ram_wr_data_o  = '0;

`ifdef INSTR_PREFETCH_EN
    localparam int CW = $clog2(DEPTH) + 1;

    logic [0:0]    state_q, state_d;
    word_addr_t    head_addr_q, head_addr_d, fill_addr_q, fill_addr_d, req_addr;
    logic          inflight_q, inflight_d;
    instr_word_t   rdata_q, rdata_d, ring_head, head_word;
    logic [CW-1:0] count;
    logic          stream_valid, head_ready, hit, miss, push, grant, unused_pf;

    assign unused_pf    = ^{instr_rd_be_i, instr_rd_addr_i[1:0]};
    assign req_addr     = instr_rd_addr_i[31:2];
    assign stream_valid = state_q == ST_STREAM;
    assign head_ready   = count != '0 || inflight_q;
    assign hit          = instr_rd_req_i && stream_valid && req_addr == head_addr_q && head_ready;
    // Gating with rst_n keeps the master request low while reset is held.
    assign miss         = rst_n && instr_rd_req_i && !hit;
    assign push         = inflight_q && !miss;
    assign head_word    = count != '0 ? ring_head : ram_rd_data_i;

    assign ram_rd_req_o    = miss || (stream_valid && (32'(count) + 32'(inflight_q)) < DEPTH);
    assign ram_rd_addr_o   = ram_rd_req_o ? {(miss ? req_addr : fill_addr_q), 2'b00} : '0;
    assign ram_rd_be_o     = ram_rd_req_o ? 4'hF : 4'h0;
    assign grant           = ram_rd_req_o && ram_rd_gnt_i;
    assign instr_rd_gnt_o  = hit;
    assign instr_rd_data_o = rdata_q;

    always_comb begin
        state_d     = (miss || stream_valid) ? ST_STREAM : ST_IDLE;
        head_addr_d = miss ? req_addr : head_addr_q + word_addr_t'(hit);
        fill_addr_d = (miss ? req_addr : fill_addr_q) + word_addr_t'(grant);
        inflight_d  = grant;
        rdata_d     = hit ? head_word : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            head_addr_q <= '0;
            fill_addr_q <= '0;
            inflight_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            head_addr_q <= head_addr_d;
            fill_addr_q <= fill_addr_d;
            inflight_q  <= inflight_d;
            rdata_q     <= rdata_d;
        end
    end

    prefetch_ring #(.DEPTH(DEPTH)) u_ring (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (ram_rd_data_i),
        .pop_i       (hit),
        .flush_i     (miss),
        .count_o     (count),
        .head_o      (ring_head)
    );
`else
    logic unused_pt;

    assign unused_pt       = clk ^ rst_n ^ (DEPTH > 0);
    assign ram_rd_req_o    = instr_rd_req_i;
    assign ram_rd_be_o     = instr_rd_be_i;
    assign ram_rd_addr_o   = instr_rd_addr_i;
    assign instr_rd_gnt_o  = ram_rd_gnt_i;
    assign instr_rd_data_o = ram_rd_data_i;
`endif
endmodule

// File: tb/tb_core_instr_prefetch.sv
// tb_core_instr_prefetch: randomized scoreboard bench for core_instr_prefetch, prefetch or pass-through build.
module tb_core_instr_prefetch;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req, s_gnt, s_wgnt, m_req, ram_gnt, m_wreq;
    logic [3:0]  be, m_be, m_wbe;
    logic [31:0] addr, s_data, m_addr, ram_data, ram_next, m_waddr, m_wdata;
    int          checks = 0, errors = 0, cyc = 0;

    typedef struct packed {
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: queue of buffered word addresses plus the word on its way back.
    logic [29:0] mq[$];
    bit          stream, inf_v, prev_g;
    logic [29:0] head, fill, inf_addr, prev_a;

    always #5 clk = ~clk;

    core_instr_prefetch #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_rd_req_i(req), .instr_rd_be_i(be), .instr_rd_addr_i(addr),
        .instr_rd_gnt_o(s_gnt), .instr_rd_data_o(s_data), .instr_wr_gnt_o(s_wgnt),
        .ram_rd_req_o(m_req), .ram_rd_be_o(m_be), .ram_rd_addr_o(m_addr),
        .ram_rd_gnt_i(ram_gnt), .ram_rd_data_i(ram_data),
        .ram_wr_req_o(m_wreq), .ram_wr_be_o(m_wbe), .ram_wr_addr_o(m_waddr), .ram_wr_data_o(m_wdata)
    );

    function automatic logic [31:0] ram_word(input logic [29:0] w);
        return ({w, 2'b01} * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic gnt_for(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return cyc[0];
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, want);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        stream = 0; inf_v = 0; prev_g = 0;
        head = '0; fill = '0; inf_addr = '0; prev_a = '0;
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic g, output bit granted);
        exp_t        e;
        logic [29:0] w;
        bit          hit, miss;
        @(negedge clk);
        cyc++;
        req = r; addr = a; ram_gnt = g; be = 4'($urandom);
        ram_data = ram_next;
        #1;
        w = a[31:2];
        e.data = prev_g ? ram_word(prev_a) : '0;
`ifdef INSTR_PREFETCH_EN
        hit  = r && stream && w == head && (mq.size() > 0 || inf_v);
        miss = r && !hit;
        e.gnt  = hit;
        e.req  = miss || (stream && mq.size() + int'(inf_v) < DEPTH);
        e.addr = e.req ? {(miss ? w : fill), 2'b00} : '0;
        e.be   = e.req ? 4'hF : 4'h0;
        if (miss) begin
            mq.delete();
            head = w; stream = 1; fill = w;
        end else begin
            if (inf_v) mq.push_back(inf_addr);
            if (hit) begin
                void'(mq.pop_front());
                head = head + 30'd1;
            end
        end
        inf_v = e.req && g;
        inf_addr = e.addr[31:2];
        if (inf_v) fill = fill + 30'd1;
        prev_g = hit;
        granted = hit;
`else
        hit = r && g;
        miss = 0;
        e.gnt = g; e.req = r; e.addr = a; e.be = be;
        prev_g = hit;
        granted = hit;
`endif
        prev_a = w;
        exp_q.push_back(e);
        ram_next = (m_req && g) ? ram_word(m_addr[31:2]) : '0;
    endtask

    task automatic run_seq(input logic [31:0] start, input int n, input int mode);
        logic [31:0] a;
        int          got, budget;
        bit          gr;
        a = start; got = 0; budget = n * 10 + 10;
        while (got < n && budget > 0) begin
            step(1'b1, a, gnt_for(mode), gr);
            if (gr) begin
                got++;
                a += 4;
            end
            budget--;
        end
        check("seq_done", 32'(got), 32'(n));
    endtask

    task automatic idle(input int n);
        bit gr;
        for (int i = 0; i < n; i++) step(1'b0, addr, 1'b1, gr);
    endtask

`ifdef INSTR_PREFETCH_EN
    task automatic mid_reset();
        #2;
        rst_n = 0;
        #1;
        check("rst_slave_gnt", 32'(s_gnt), 0);
        check("rst_slave_data", s_data, 0);
        check("rst_master_req", 32'(m_req), 0);
        check("rst_master_addr", m_addr, 0);
        check("rst_master_be", 32'(m_be), 0);
        req = 0;
        rst_n = 1;
        model_reset();
    endtask
`endif

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("slave_gnt", 32'(s_gnt), 32'(e.gnt));
                check("slave_data", s_data, e.data);
                check("master_req", 32'(m_req), 32'(e.req));
                check("master_addr", m_addr, e.addr);
                check("master_be", 32'(m_be), 32'(e.be));
                check("write_tie", 32'(|{s_wgnt, m_wreq, m_wbe, m_waddr, m_wdata}), 0);
            end
        end
    end

    initial begin : driver
        logic [31:0] a;
        bit          gr;
        req = 0; addr = '0; be = '0; ram_gnt = 0; ram_data = '0; ram_next = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_slave_gnt", 32'(s_gnt), 0);
        check("reset_slave_data", s_data, 0);
        check("reset_master_req", 32'(m_req), 0);
        check("reset_master_addr", m_addr, 0);
        check("reset_master_be", 32'(m_be), 0);
        rst_n = 1;
        idle(2);
        run_seq(32'h100, 16, 0);
        run_seq(32'h100, 3, 0);
        idle(1);
        run_seq(32'h400, 4, 0);
        run_seq(32'h800, 12, 1);
        run_seq(32'hFFFF_FFF8, 4, 0);
        run_seq(32'hFFFF_FFF4, 5, 2);
`ifdef INSTR_PREFETCH_EN
        run_seq(32'h200, 2, 0);
        idle(3);
        step(1'b1, 32'h208, 1'b1, gr);
        mid_reset();
        idle(4);
        run_seq(32'h300, 4, 0);
`endif
        a = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            step($urandom_range(0, 3) != 0, a, gnt_for(2), gr);
            if (gr) a += 4;
        end
        idle(2);
        @(negedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
